// File: rtl/sram_fifo_pkg.sv
// ============================================================================
// Module      : sram_fifo_pkg
// Description : Shared macro geometry and sizing helpers for the banked FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_fifo_pkg;

    localparam int MACRO_WIDTH = 8;
    localparam int MACRO_DEPTH = 16;

    // Number of 8-bit macro lanes needed to hold one word.
    function automatic int lanes(input int data_width);
        return data_width / MACRO_WIDTH;
    endfunction

    // Bank-select bits taken from the top of the pointer; zero for one bank.
    function automatic int bank_bits(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sky130_sram_1r1w_8x16.sv
// ============================================================================
// Module      : sky130_sram_1r1w_8x16
// Description : Behavioural model of the 8x16 1r1w macro, 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sky130_sram_1r1w_8x16 (
    input  logic       clk0,
    input  logic       csb0,
    input  logic [3:0] addr0,
    input  logic [7:0] din0,
    input  logic       clk1,
    input  logic       csb1,
    input  logic [3:0] addr1,
    output logic [7:0] dout1
);

    logic [7:0] r_mem [16];

    always_ff @(posedge clk0) begin
        if (!csb0) begin
            r_mem[addr0] <= din0;
        end
    end

    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= r_mem[addr1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_bank_array.sv
// ============================================================================
// Module      : sram_bank_array
// Description : NUM_BANKS x lanes array of 1r1w macros; pure storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bank_array
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_WIDTH = $clog2(MACRO_DEPTH * NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int c_LANES     = lanes(DATA_WIDTH);
    localparam int c_BANK_BITS = bank_bits(NUM_BANKS);
    localparam int c_SEL_W     = (c_BANK_BITS > 0) ? c_BANK_BITS : 1;

    logic [c_SEL_W-1:0]    w_wbank;
    logic [c_SEL_W-1:0]    w_rbank;
    logic [DATA_WIDTH-1:0] w_bank_dout [NUM_BANKS];

    generate
        if (c_BANK_BITS > 0) begin : g_multi_bank
            logic [c_SEL_W-1:0] r_rbank;

            assign w_wbank = waddr[ADDR_WIDTH-1 -: c_BANK_BITS];
            assign w_rbank = raddr[ADDR_WIDTH-1 -: c_BANK_BITS];

            // The mux follows the bank of the read that was issued, since the
            // read pointer has already moved on when the data appears.
            always_ff @(posedge clk) begin
                if (ren) begin
                    r_rbank <= w_rbank;
                end
            end

            assign rdata = w_bank_dout[r_rbank];
        end else begin : g_single_bank
            assign w_wbank = '0;
            assign w_rbank = '0;
            assign rdata   = w_bank_dout[0];
        end

        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            localparam logic [c_SEL_W-1:0] c_BANK_ID = c_SEL_W'(b);
            logic                  w_csb0;
            logic                  w_csb1;
            logic [DATA_WIDTH-1:0] w_dout;

            assign w_csb0         = ~(wen & (w_wbank == c_BANK_ID));
            assign w_csb1         = ~(ren & (w_rbank == c_BANK_ID));
            assign w_bank_dout[b] = w_dout;

            for (genvar l = 0; l < c_LANES; l++) begin : g_lane
                sky130_sram_1r1w_8x16 u_macro (
                    .clk0  (clk),
                    .csb0  (w_csb0),
                    .addr0 (waddr[3:0]),
                    .din0  (wdata[l*MACRO_WIDTH +: MACRO_WIDTH]),
                    .clk1  (clk),
                    .csb1  (w_csb1),
                    .addr1 (raddr[3:0]),
                    .dout1 (w_dout[l*MACRO_WIDTH +: MACRO_WIDTH])
                );
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sram_fifo_banked.sv
// ============================================================================
// Module      : sram_fifo_banked
// Description : FWFT FIFO on banked SRAM macros with a 2-entry output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_banked
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BANK_DEPTH = MACRO_DEPTH,
    parameter int NUM_BANKS  = 2,
    parameter int RAM_DEPTH  = BANK_DEPTH * NUM_BANKS,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int c_CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [c_CNT_W-1:0]    r_mem_cnt;
    logic                  r_inflight;
    logic [1:0]            r_ob_cnt;
    logic [DATA_WIDTH-1:0] r_ob_head;
    logic [DATA_WIDTH-1:0] r_ob_tail;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_push_acc;
    logic                  w_pop_acc;
    logic [2:0]            w_ob_demand;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_ram_rdata;
    logic [1:0]            w_ob_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_ob_head_nxt;
    logic [DATA_WIDTH-1:0] w_ob_tail_nxt;

    assign count     = r_mem_cnt + c_CNT_W'(r_inflight) + c_CNT_W'(r_ob_cnt);
    assign full      = (count == c_CNT_W'(RAM_DEPTH));
    assign rvalid    = (r_ob_cnt != 2'd0);
    assign rdata     = r_ob_head;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    assign w_push_acc  = push & ~full;
    assign w_pop_acc   = pop & rvalid;
    // Buffer slots still claimed after this cycle's pop; never negative
    // because a pop is only accepted with at least one word buffered.
    assign w_ob_demand = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop_acc};
    assign w_issue     = (r_mem_cnt != '0) && (w_ob_demand < 3'd2);

    sram_bank_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .wen   (w_push_acc),
        .waddr (r_wptr),
        .wdata (wdata),
        .ren   (w_issue),
        .raddr (r_rptr),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_ob_cnt_nxt  = r_ob_cnt;
        w_ob_head_nxt = r_ob_head;
        w_ob_tail_nxt = r_ob_tail;
        case ({w_pop_acc, r_inflight})
            2'b10: begin
                w_ob_head_nxt = r_ob_tail;
                w_ob_cnt_nxt  = r_ob_cnt - 2'd1;
            end
            2'b01: begin
                if (r_ob_cnt == 2'd0) begin
                    w_ob_head_nxt = w_ram_rdata;
                end else begin
                    w_ob_tail_nxt = w_ram_rdata;
                end
                w_ob_cnt_nxt = r_ob_cnt + 2'd1;
            end
            2'b11: begin
                if (r_ob_cnt == 2'd1) begin
                    w_ob_head_nxt = w_ram_rdata;
                end else begin
                    w_ob_head_nxt = r_ob_tail;
                    w_ob_tail_nxt = w_ram_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_mem_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_ob_cnt    <= 2'd0;
            r_ob_head   <= '0;
            r_ob_tail   <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_mem_cnt  <= r_mem_cnt + c_CNT_W'(w_push_acc) - c_CNT_W'(w_issue);
            r_inflight <= w_issue;
            r_ob_cnt   <= w_ob_cnt_nxt;
            r_ob_head  <= w_ob_head_nxt;
            r_ob_tail  <= w_ob_tail_nxt;
            if (push && full) begin
                r_overflow <= 1'b1;
            end
            if (pop && !rvalid) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_banked.sv
// ============================================================================
// Module      : tb_sram_fifo_banked
// Description : Self-checking bench for sram_fifo_banked (default and 4x16 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_fifo_banked;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       push, pop;
    logic [7:0] wdata, rdata;
    logic       full, rvalid, overflow, underflow;
    logic [5:0] count;

    logic        push4, pop4;
    logic [15:0] wdata4, rdata4;
    logic        full4, rvalid4, overflow4, underflow4;
    logic [6:0]  count4;

    sram_fifo_banked dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (wdata),
        .full      (full),
        .pop       (pop),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    sram_fifo_banked #(.DATA_WIDTH(16), .NUM_BANKS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .push      (push4),
        .wdata     (wdata4),
        .full      (full4),
        .pop       (pop4),
        .rdata     (rdata4),
        .rvalid    (rvalid4),
        .count     (count4),
        .overflow  (overflow4),
        .underflow (underflow4)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sb[$];
    int          m_cnt;
    logic        m_ovf, m_unf;
    logic [15:0] sb4[$];
    int          m_cnt4;
    logic        m_ovf4, m_unf4;

    typedef struct {
        logic       do_rst;
        logic       p;
        logic [7:0] d;
        logic       q;
        logic       rv;
        logic [7:0] rd;
        int         cnt;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; push4 = 1'b0; pop4 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete(); m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        sb4.delete(); m_cnt4 = 0; m_ovf4 = 1'b0; m_unf4 = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
    endtask

    // One clock of stimulus on the default build; scoreboard and flags updated
    // from the bench's own occupancy model.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        logic pre_full;
        pre_full = (m_cnt == 32);
        if (q && rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop_unexpected: rdata %0h with nothing expected", rdata);
            end else begin
                chk("pop_data", 32'(rdata), 32'(sb.pop_front()));
            end
            m_cnt--;
        end else if (q) begin
            m_unf = 1'b1;
        end
        if (p) begin
            if (pre_full) m_ovf = 1'b1;
            else begin
                sb.push_back(d);
                m_cnt++;
            end
        end
        push = p; wdata = d; pop = q;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 32));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic step4(input logic p, input logic [15:0] d, input logic q);
        logic pre_full;
        pre_full = (m_cnt4 == 64);
        if (q && rvalid4) begin
            if (sb4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pop4_unexpected: rdata %0h with nothing expected", rdata4);
            end else begin
                chk("pop4_data", 32'(rdata4), 32'(sb4.pop_front()));
            end
            m_cnt4--;
        end else if (q) begin
            m_unf4 = 1'b1;
        end
        if (p) begin
            if (pre_full) m_ovf4 = 1'b1;
            else begin
                sb4.push_back(d);
                m_cnt4++;
            end
        end
        push4 = p; wdata4 = d; pop4 = q;
        @(posedge clk);
        #1;
        push4 = 1'b0; pop4 = 1'b0;
        chk("count4", 32'(count4), 32'(m_cnt4));
        chk("full4", 32'(full4), 32'(m_cnt4 == 64));
        chk("overflow4", 32'(overflow4), 32'(m_ovf4));
        chk("underflow4", 32'(underflow4), 32'(m_unf4));
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && m_cnt > 0; k++) step(1'b0, 8'h00, rvalid);
        chk({tag, "_drained"}, 32'(m_cnt), 0);
        step(1'b0, 8'h00, 1'b0);
        chk({tag, "_rvalid_low"}, 32'(rvalid), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; wdata = '0;
        push4 = 1'b0; pop4 = 1'b0; wdata4 = '0;

        //         rst   push  data   pop   rvalid rdata  count
        vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vt[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1};
        vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, 1};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};
        vt[11] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1};
        vt[12] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2};
        vt[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 2};
        vt[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1};
        vt[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

        for (int i = 0; i < 16; i++) begin
            if (vt[i].do_rst) do_reset();
            else step(vt[i].p, vt[i].d, vt[i].q);
            chk("vec_rvalid", 32'(rvalid), 32'(vt[i].rv));
            if (vt[i].rv) chk("vec_rdata", 32'(rdata), 32'(vt[i].rd));
            chk("vec_count", 32'(count), 32'(vt[i].cnt));
        end

        // Fill to capacity, overflow, push+pop while full, then drain in order.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 30) chk("fill_not_full_31", 32'(full), 0);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 32);
        step(1'b1, 8'hFF, 1'b0);
        chk("ovf_count", 32'(count), 32);
        step(1'b1, 8'hEE, 1'b1);
        chk("full_pushpop_count", 32'(count), 31);
        drain("fill");

        // Pointer wrap across bank 1 -> bank 0.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("wrap_count_a", 32'(count), 20);
        drain("wrap_a");
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        chk("wrap_count_b", 32'(count), 20);
        drain("wrap_b");

        // Sustained push+pop: one word per cycle with no bubbles.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        for (int i = 4; i < 104; i++) begin
            chk("steady_rvalid", 32'(rvalid), 1);
            step(1'b1, 8'(i), 1'b1);
        end
        chk("steady_count", 32'(count), 4);
        drain("steady");

        // Reset mid-stream with a read in flight.
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("mid_count", 32'(count), 10);
        do_reset();
        step(1'b1, 8'h77, 1'b0);
        chk("post_rst_rvalid_e0", 32'(rvalid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_rvalid_e1", 32'(rvalid), 0);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_rvalid_e2", 32'(rvalid), 1);
        chk("post_rst_rdata", 32'(rdata), 32'h77);
        drain("post_rst");

        // Four banks, 16-bit words: 64 entries.
        do_reset();
        chk("b4_rst_count", 32'(count4), 0);
        chk("b4_rst_rvalid", 32'(rvalid4), 0);
        for (int i = 0; i < 64; i++) begin
            step4(1'b1, {8'(i), 8'(~i)}, 1'b0);
            if (i == 62) chk("b4_not_full_63", 32'(full4), 0);
        end
        chk("b4_full", 32'(full4), 1);
        chk("b4_count", 32'(count4), 64);
        step4(1'b1, 16'hFFFF, 1'b0);
        for (int k = 0; k < 300 && m_cnt4 > 0; k++) step4(1'b0, 16'h0000, rvalid4);
        chk("b4_drained", 32'(m_cnt4), 0);
        step4(1'b0, 16'h0000, 1'b0);
        chk("b4_rvalid_low", 32'(rvalid4), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
